// File: rtl/vpu_pkg.sv
// Shared widths, latencies and the source-port FSM state type for the VPU
// operand fetch path.
package vpu_pkg;

   localparam int OPERAND_WIDTH   = 16;
   localparam int SRAM_R_PORT_CNT = 3;
   localparam int SRAM_ADDR_WIDTH = 8;
   localparam int SRAM_RD_LAT     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } src_port_state_t;

endpackage

// File: rtl/vpu_src_fifo.sv
// Show-ahead synchronous FIFO buffering one operand set per entry; the head
// entry is visible on pop_data whenever the FIFO is non-empty.
module vpu_src_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   assign count    = count_reg;
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr_reg];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/vpu_src_port.sv
// Vector source port: streams 2 or 3 operand vectors out of SRAM read ports
// into a credit-controlled FIFO and presents them to the ALU as operand sets.
module vpu_src_port
   import vpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            start_i,
   input  logic [1:0]                                      src_cnt_i,
   input  logic [LEN_WIDTH-1:0]                            len_i,
   input  logic [SRAM_R_PORT_CNT-1:0][SRAM_ADDR_WIDTH-1:0] base_addr_i,
   output logic [SRAM_R_PORT_CNT-1:0]                      sram_re_o,
   output logic [SRAM_R_PORT_CNT-1:0][SRAM_ADDR_WIDTH-1:0] sram_raddr_o,
   input  logic [SRAM_R_PORT_CNT-1:0][OPERAND_WIDTH-1:0]   sram_rdata_i,
   output logic [OPERAND_WIDTH-1:0]                        op_0,
   output logic [OPERAND_WIDTH-1:0]                        op_1,
   output logic [OPERAND_WIDTH-1:0]                        op_2,
   output logic [SRAM_R_PORT_CNT-1:0]                      op_valid,
   input  logic                                            op_ready_i,
   output logic                                            busy_o,
   output logic                                            done_o
);

   localparam int P  = SRAM_R_PORT_CNT;
   localparam int OW = OPERAND_WIDTH;
   localparam int AW = SRAM_ADDR_WIDTH;
   localparam int DW = P * OW;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   src_port_state_t              state_reg;
   src_port_state_t              state_next;
   logic [1:0]                   src_cnt_reg;
   logic [LEN_WIDTH-1:0]         len_reg;
   logic [LEN_WIDTH-1:0]         issue_cnt_reg;
   logic [LEN_WIDTH-1:0]         pop_cnt_reg;
   logic [P-1:0][AW-1:0]         addr_reg;
   logic [SRAM_RD_LAT-1:0]       vld_pipe_reg;

   logic [P-1:0]                 port_en;
   logic                         accept;
   logic                         issue;
   logic                         last_issue;
   logic                         pop_fire;
   logic                         last_pop;
   logic                         credit_ok;
   logic [CW:0]                  inflight;
   logic [CW:0]                  occupancy;

   logic [DW-1:0]                push_data;
   logic [DW-1:0]                head_data;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [CW-1:0]                fifo_count;

   assign accept     = (state_reg == IDLE) && start_i;
   assign pop_fire   = !fifo_empty && op_ready_i;
   assign issue      = (state_reg == ISSUE) && credit_ok;
   assign last_issue = issue && (issue_cnt_reg == len_reg - LEN_WIDTH'(1));
   assign last_pop   = pop_fire && (pop_cnt_reg == len_reg - LEN_WIDTH'(1));

   // Every issued read reserves a slot until it leaves the FIFO, so returning
   // data always has room; a pop in this cycle frees its slot immediately.
   always_comb begin
      inflight = '0;
      for (int k = 0; k < SRAM_RD_LAT; k++) begin
         inflight = inflight + (CW+1)'(vld_pipe_reg[k]);
      end
   end

   assign occupancy = inflight + {1'b0, fifo_count} - (CW+1)'(pop_fire);
   assign credit_ok = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));

   always_comb begin
      state_next = state_reg;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = (len_i == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            busy_o = 1'b1;
            if (last_issue) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (last_pop) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         src_cnt_reg   <= '0;
         len_reg       <= '0;
         issue_cnt_reg <= '0;
         pop_cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            src_cnt_reg   <= src_cnt_i;
            len_reg       <= len_i;
            issue_cnt_reg <= '0;
            pop_cnt_reg   <= '0;
         end else begin
            if (issue) begin
               issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
            end
            if (pop_fire) begin
               pop_cnt_reg <= pop_cnt_reg + LEN_WIDTH'(1);
            end
         end
      end
   end

   genvar gi;

   // Read-return tracker: a bit enters on issue and becomes a FIFO push exactly
   // SRAM_RD_LAT cycles later. Clearing it on reset discards stale returns.
   generate
      for (gi = 0; gi < SRAM_RD_LAT; gi++) begin : g_vld_pipe
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
               vld_pipe_reg[gi] <= issue;
            end else begin
               vld_pipe_reg[gi] <= vld_pipe_reg[(gi == 0) ? 0 : gi-1];
            end
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < P; gi++) begin : g_port
         assign port_en[gi] = (gi < int'(src_cnt_reg));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               addr_reg[gi] <= '0;
            end else if (accept) begin
               addr_reg[gi] <= base_addr_i[gi];
            end else if (issue) begin
               addr_reg[gi] <= addr_reg[gi] + AW'(1);
            end
         end

         assign sram_re_o[gi]    = issue && port_en[gi];
         assign sram_raddr_o[gi] = sram_re_o[gi] ? addr_reg[gi] : '0;
         assign op_valid[gi]     = !fifo_empty && port_en[gi];
      end
   endgenerate

   assign push_data = sram_rdata_i;

   vpu_src_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (vld_pipe_reg[SRAM_RD_LAT-1]),
      .push_data (push_data),
      .pop       (pop_fire),
      .pop_data  (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Unused port lanes of the head entry hold undefined read data, so mask them.
   assign op_0 = op_valid[0] ? head_data[0*OW +: OW] : '0;
   assign op_1 = op_valid[1] ? head_data[1*OW +: OW] : '0;
   assign op_2 = op_valid[2] ? head_data[2*OW +: OW] : '0;

endmodule
